// File: rtl/pad_frame_filt_pkg.sv
// pad_frame_filt_pkg
//   Shared types and helpers for the filtered pad frame.
//   - strap_state_e : boot-strap latch FSM states
//   - cfg_state_e   : pad-configuration handshake FSM states
//   - strap_cnt_w() : width of the strap delay counter for a given delay
package pad_frame_filt_pkg;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        WAIT    = 2'd1,
        LATCHED = 2'd2
    } strap_state_e;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_e;

    // Counter must be able to hold STRAP_DELAY itself.
    function automatic int strap_cnt_w(input int strap_delay);
        return $clog2(strap_delay + 1);
    endfunction

endpackage

// File: rtl/pad_functional_pd.sv
// pad_functional_pd
//   Behavioural model of the bidirectional pad cell with a pull-down.
//   Ports:
//     OEN : output enable, active low
//     I   : data driven onto the pad when OEN=0
//     O   : pad level seen by the core
//     PEN : pull enable, active low (pull-down toward 0)
//     PAD : the chip pin
//   The pull-down is modelled as a driver of 0 that is only active while the
//   output buffer is off, so it never fights the cell's own output.
module pad_functional_pd (
    input  logic OEN,
    input  logic I,
    output logic O,
    input  logic PEN,
    inout  wire  PAD
);

    logic drive_en;
    logic drive_val;

    assign drive_en  = ~OEN | ~PEN;
    assign drive_val = ~OEN & I;

    assign PAD = drive_en ? drive_val : 1'bz;
    assign O   = PAD;

endmodule

// File: rtl/pad_in_filter.sv
// pad_in_filter
//   Per-pad input conditioning: synchroniser, programmable glitch filter and
//   edge detection.
//   Ports:
//     clk_i, rst_ni : clock, synchronous active-low reset
//     pad_i         : raw asynchronous pad level
//     filt_en_i     : 1 = filter active, 0 = bypass
//     filt_len_i    : filter length L; a new level is accepted after L+1
//                     consecutive cycles of disagreement
//     edge_en_i     : gates the edge pulses (frame not yet operational)
//     q_o           : stable filtered level
//     rise_o/fall_o : one-cycle pulses on the first cycle q_o shows a change
module pad_in_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pad_i,
    input  logic              filt_en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic              edge_en_i,
    output logic              q_o,
    output logic              rise_o,
    output logic              fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   q;
    logic                   q_d;
    logic [FILT_W-1:0]      cnt_q;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            q      <= 1'b0;
            q_d    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            q_d    <= q;
            if (!filt_en_i) begin
                q     <= sync_s;
                cnt_q <= '0;
            end else if (sync_s == q) begin
                cnt_q <= '0;
            end else if (cnt_q >= filt_len_i) begin
                // '>=' so that lowering L mid-count takes effect at once
                q     <= sync_s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + FILT_W'(1);
            end
        end
    end

    assign q_o    = q;
    assign rise_o = q & ~q_d & edge_en_i;
    assign fall_o = ~q & q_d & edge_en_i;

endmodule

// File: rtl/pad_frame_filt.sv
// pad_frame_filt
//   Pad frame with per-pad synchroniser/glitch filter, edge pulses, a shadow
//   pad-configuration register and boot-strap latching.
//   Ports:
//     clk_i, rst_ni    : clock, synchronous active-low reset
//     pad_cfg_i        : new per-pad configuration (bit 0 = pull enable)
//     cfg_valid_i      : configuration update request
//     cfg_ready_o      : configuration accept
//     filt_len_i       : global filter length L
//     filt_en_i        : per-pad filter enable
//     io_out_i/io_oe_i : output data / active-high output enable per pad
//     io_in_o          : synchronised, filtered pad level
//     io_rise_o/fall_o : one-cycle edge pulses
//     stm_o, bootsel_o : latched boot straps
//     straps_valid_o   : straps latched, frame operational
//     io               : chip pins
//   FSM state is visible as strap_state_q / cfg_state_q.
module pad_frame_filt
    import pad_frame_filt_pkg::*;
#(
    parameter int N_IO        = 56,
    parameter int NBIT_PADCFG = 6,
    parameter int SYNC_STAGES = 2,   // must be >= 2
    parameter int FILT_W      = 8,
    parameter int STRAP_DELAY = 16,  // must be >= 1
    parameter int STM_IDX     = 45,
    parameter int BOOTSEL_IDX = 46
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [N_IO-1:0][NBIT_PADCFG-1:0]  pad_cfg_i,
    input  logic                              cfg_valid_i,
    output logic                              cfg_ready_o,
    input  logic [FILT_W-1:0]                 filt_len_i,
    input  logic [N_IO-1:0]                   filt_en_i,
    input  logic [N_IO-1:0]                   io_out_i,
    input  logic [N_IO-1:0]                   io_oe_i,
    output logic [N_IO-1:0]                   io_in_o,
    output logic [N_IO-1:0]                   io_rise_o,
    output logic [N_IO-1:0]                   io_fall_o,
    output logic                              stm_o,
    output logic                              bootsel_o,
    output logic                              straps_valid_o,
    inout  wire  [N_IO-1:0]                   io
);

    localparam int STRAP_CNT_W = strap_cnt_w(STRAP_DELAY);

    // ------------------------------------------------------------------
    // Boot-strap FSM
    // ------------------------------------------------------------------
    strap_state_e            strap_state_q, strap_state_d;
    logic [STRAP_CNT_W-1:0]  strap_cnt_q, strap_cnt_d;
    logic                    stm_d, bootsel_d;

    always_comb begin
        strap_state_d = strap_state_q;
        strap_cnt_d   = strap_cnt_q;
        stm_d         = stm_o;
        bootsel_d     = bootsel_o;
        unique case (strap_state_q)
            RESET: begin
                strap_state_d = WAIT;
                strap_cnt_d   = '0;
            end
            WAIT: begin
                if (strap_cnt_q == STRAP_CNT_W'(STRAP_DELAY - 1)) begin
                    stm_d         = io_in_o[STM_IDX];
                    bootsel_d     = io_in_o[BOOTSEL_IDX];
                    strap_state_d = LATCHED;
                end else begin
                    strap_cnt_d = strap_cnt_q + STRAP_CNT_W'(1);
                end
            end
            LATCHED: begin
                strap_state_d = LATCHED;
            end
            default: begin
                strap_state_d = RESET;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            strap_state_q <= RESET;
            strap_cnt_q   <= '0;
            stm_o         <= 1'b0;
            bootsel_o     <= 1'b0;
        end else begin
            strap_state_q <= strap_state_d;
            strap_cnt_q   <= strap_cnt_d;
            stm_o         <= stm_d;
            bootsel_o     <= bootsel_d;
        end
    end

    assign straps_valid_o = (strap_state_q == LATCHED);

    // ------------------------------------------------------------------
    // Configuration handshake
    // Valid/ready: a transfer happens on a rising edge where cfg_valid_i and
    // cfg_ready_o are both 1. The requester may hold cfg_valid_i; ready drops
    // for one cycle after each transfer, so a held request is taken again
    // only once ready returns.
    // ------------------------------------------------------------------
    cfg_state_e                       cfg_state_q, cfg_state_d;
    logic                             cfg_load;
    logic [N_IO-1:0][NBIT_PADCFG-1:0] cfg_q;

    always_comb begin
        cfg_state_d = cfg_state_q;
        cfg_ready_o = 1'b0;
        cfg_load    = 1'b0;
        unique case (cfg_state_q)
            IDLE: begin
                cfg_ready_o = straps_valid_o;
                if (cfg_valid_i && straps_valid_o) begin
                    cfg_load    = 1'b1;
                    cfg_state_d = APPLY;
                end
            end
            APPLY: begin
                cfg_state_d = IDLE;
            end
            default: begin
                cfg_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cfg_state_q <= IDLE;
            cfg_q       <= '0;
        end else begin
            cfg_state_q <= cfg_state_d;
            if (cfg_load) begin
                cfg_q <= pad_cfg_i;
            end
        end
    end

    // Only the pull-enable bit reaches this cell; the rest is kept in the
    // shadow register for neighbouring logic.
    logic unused_cfg;
    assign unused_cfg = ^cfg_q;

    // ------------------------------------------------------------------
    // Pad cells and input conditioning
    // ------------------------------------------------------------------
    logic [N_IO-1:0] pad_oen;
    logic [N_IO-1:0] pad_pen;
    logic [N_IO-1:0] pad_lvl;

    for (genvar i = 0; i < N_IO; i++) begin : g_pad
        // Input-only until the straps have been sampled.
        assign pad_oen[i] = ~(io_oe_i[i] & straps_valid_o);
        assign pad_pen[i] = ~cfg_q[i][0];

        pad_functional_pd u_pad (
            .OEN (pad_oen[i]),
            .I   (io_out_i[i]),
            .O   (pad_lvl[i]),
            .PEN (pad_pen[i]),
            .PAD (io[i])
        );

        pad_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W)
        ) u_filt (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .pad_i      (pad_lvl[i]),
            .filt_en_i  (filt_en_i[i]),
            .filt_len_i (filt_len_i),
            .edge_en_i  (straps_valid_o),
            .q_o        (io_in_o[i]),
            .rise_o     (io_rise_o[i]),
            .fall_o     (io_fall_o[i])
        );
    end

endmodule

// File: tb/tb_pad_frame_filt.sv
// tb_pad_frame_filt
//   Randomised bench for pad_frame_filt with a behavioural reference model
//   and directed literal checks of strap timing, filter latency, bypass
//   latency, config handshake and mid-run reset.
module tb_pad_frame_filt;

  localparam int N_IO   = 56;
  localparam int NBIT   = 6;
  localparam int SYNC   = 2;
  localparam int FILT_W = 8;
  localparam int SD     = 16;
  localparam int STM    = 45;
  localparam int BOOT   = 46;
  localparam int N_OUT  = 10;  // pads 0..9 are left to the DUT's drivers

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N_IO-1:0][NBIT-1:0] pad_cfg;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [FILT_W-1:0]         filt_len;
  logic [N_IO-1:0]           filt_en, io_out, io_oe, io_in, io_rise, io_fall;
  logic                      stm, bootsel, straps_valid;
  wire  [N_IO-1:0]           io;
  logic [N_IO-1:0]           tb_val, tb_en;

  for (genvar g = 0; g < N_IO; g++) begin : g_drv
    assign io[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  pad_frame_filt dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .pad_cfg_i      (pad_cfg),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .filt_len_i     (filt_len),
    .filt_en_i      (filt_en),
    .io_out_i       (io_out),
    .io_oe_i        (io_oe),
    .io_in_o        (io_in),
    .io_rise_o      (io_rise),
    .io_fall_o      (io_fall),
    .stm_o          (stm),
    .bootsel_o      (bootsel),
    .straps_valid_o (straps_valid),
    .io             (io)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pad level history, accepted levels and mismatch run lengths; straps are
  // tracked as "edges since reset release".
  logic [N_IO-1:0]           m_hist [SYNC];
  logic [N_IO-1:0]           m_q  = '0;
  logic [N_IO-1:0]           m_qd = '0;
  int                        m_run [N_IO];
  int                        m_rel   = 0;
  logic                      m_stm   = 1'b0;
  logic                      m_boot  = 1'b0;
  logic                      m_apply = 1'b0;
  logic [N_IO-1:0][NBIT-1:0] m_cfg   = '0;

  function automatic logic [N_IO-1:0] pad_level(input logic valid);
    logic [N_IO-1:0] v;
    for (int i = 0; i < N_IO; i++)
      v[i] = tb_en[i] ? tb_val[i] : (io_oe[i] & io_out[i] & valid);
    return v;
  endfunction

  always @(posedge clk) begin : model
    logic [N_IO-1:0] lvl, s, oq;
    logic            v_pre;
    v_pre = (m_rel == SD + 1);
    if (!rst_n) begin
      for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
      for (int i = 0; i < N_IO; i++) m_run[i] = 0;
      m_q = '0; m_qd = '0; m_rel = 0; m_stm = 1'b0; m_boot = 1'b0;
      m_apply = 1'b0; m_cfg = '0;
    end else begin
      lvl = pad_level(v_pre);
      s   = m_hist[SYNC-1];
      oq  = m_q;
      if (cfg_valid && v_pre && !m_apply) begin
        m_cfg   = pad_cfg;
        m_apply = 1'b1;
      end else begin
        m_apply = 1'b0;
      end
      if (m_rel <= SD) begin
        m_rel++;
        if (m_rel == SD + 1) begin
          m_stm  = oq[STM];
          m_boot = oq[BOOT];
        end
      end
      for (int i = 0; i < N_IO; i++) begin
        if (!filt_en[i]) begin
          m_q[i] = s[i]; m_run[i] = 0;
        end else if (s[i] == oq[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] > int'(filt_len)) begin
            m_q[i] = s[i]; m_run[i] = 0;
          end
        end
      end
      m_qd = oq;
      for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = lvl;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic            v;
    logic [N_IO-1:0] ex_pen;
    v = (m_rel == SD + 1);
    for (int i = 0; i < N_IO; i++) ex_pen[i] = ~m_cfg[i][0];
    check("io_in",        64'(io_in),        64'(m_q));
    check("io_rise",      64'(io_rise),      64'(m_q & ~m_qd & {N_IO{v}}));
    check("io_fall",      64'(io_fall),      64'(~m_q & m_qd & {N_IO{v}}));
    check("straps_valid", 64'(straps_valid), 64'(v));
    check("straps",       64'({stm, bootsel}), 64'({m_stm, m_boot}));
    check("cfg_ready",    64'(cfg_ready),    64'(v & ~m_apply));
    check("pad_pen",      64'(dut.pad_pen),  64'(ex_pen));
    check("io_drive",     64'(io[N_OUT-1:0]),
          64'(io_oe[N_OUT-1:0] & io_out[N_OUT-1:0] & {N_OUT{v}}));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_cfg();
    for (int i = 0; i < N_IO; i++) begin
      pad_cfg[i] = NBIT'($urandom);
      if (i >= N_OUT) pad_cfg[i][0] = 1'b0;  // no pull fighting the bench
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int   rise20, glitch_bad, caps, n_rise, n_fall, lat;
    logic hist [24];
    logic ex;

    tb_en     = {{(N_IO-N_OUT){1'b1}}, {N_OUT{1'b0}}};
    tb_val    = '0;
    tb_val[STM] = 1'b1;
    tb_val[20]  = 1'b1;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    pad_cfg   = '0;
    filt_len  = '0;
    filt_en   = '0;
    io_out    = '0;
    io_oe     = '0;
    repeat (3) tick();
    check("rst_io_in",  64'(io_in), 64'(0));
    check("rst_valid",  64'(straps_valid), 64'(0));
    check("rst_ready",  64'(cfg_ready), 64'(0));
    check("rst_straps", 64'({stm, bootsel}), 64'(0));

    // Strap latch: pads want to drive but must stay input-only until cycle 17.
    io_oe[N_OUT-1:0]  = '1;
    io_out[N_OUT-1:0] = '1;
    rst_n  = 1'b1;
    rise20 = 0;
    for (int k = 1; k <= SD + 1; k++) begin
      tick();
      if (!straps_valid && io_rise[20]) rise20++;
      if (k == 5)  check("io_hiz", 64'(io[N_OUT-1:0]), 64'(0));
      if (k == SD) check("valid_early", 64'(straps_valid), 64'(0));
    end
    check("valid_at_17",   64'(straps_valid), 64'(1));
    check("strap_values",  64'({stm, bootsel}), 64'(2'b10));
    check("rise20_masked", 64'(rise20), 64'(0));
    check("io_driven",     64'(io[N_OUT-1:0]), 64'(10'h3ff));

    // Glitch of 3 cycles with L=4 must be rejected.
    filt_en[10] = 1'b1;
    filt_len    = 8'd4;
    repeat (2) tick();
    tb_val[10] = 1'b1;
    repeat (3) tick();
    tb_val[10] = 1'b0;
    glitch_bad = 0;
    repeat (10) begin
      tick();
      if (io_in[10] || io_rise[10]) glitch_bad++;
    end
    check("glitch_rejected", 64'(glitch_bad), 64'(0));

    // Held change: accepted 2+1+4 = 7 cycles after the pad edge.
    tb_val[10] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("filt_latency", 64'(io_in[10]),   64'(k >= 7));
      check("filt_rise",    64'(io_rise[10]), 64'(k == 7));
    end

    // Bypass: 3-cycle latency, toggling every 4 cycles.
    filt_en[10] = 1'b0;
    n_rise = 0;
    n_fall = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      ex = (k < 3) ? 1'b1 : hist[k-3];
      check("bypass_latency", 64'(io_in[10]), 64'(ex));
      n_rise += int'(io_rise[10]);
      n_fall += int'(io_fall[10]);
      hist[k] = ((k / 4) % 2) == 1;
      tb_val[10] = hist[k];
    end
    check("bypass_rises", 64'(n_rise), 64'(3));
    check("bypass_falls", 64'(n_fall), 64'(3));

    // Config transfer: ready 1 -> 0 -> 1, pull of pad 8 enabled next cycle.
    check("cfg_ready_idle", 64'(cfg_ready), 64'(1));
    rand_cfg();
    pad_cfg[8][0] = 1'b1;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("cfg_ready_apply", 64'(cfg_ready), 64'(0));
    check("pen8_on",         64'(dut.pad_pen[8]), 64'(0));
    tick();
    check("cfg_ready_back",  64'(cfg_ready), 64'(1));

    // Valid held 3 cycles: captures in the 1st and 3rd only.
    caps = 0;
    for (int k = 0; k < 3; k++) begin
      pad_cfg[8][0] = (k == 1);
      cfg_valid = 1'b1;
      caps += int'(cfg_ready);
      tick();
    end
    cfg_valid = 1'b0;
    check("cfg_captures", 64'(caps), 64'(2));
    check("pen8_last",    64'(dut.pad_pen[8]), 64'(1));

    // Randomised traffic, including occasional resets.
    for (int n = 0; n < 1500; n++) begin
      tick();
      for (int i = N_OUT; i < N_IO; i++)
        if ($urandom_range(0, 5) == 0) tb_val[i] = ~tb_val[i];
      io_out[N_OUT-1:0] = N_OUT'($urandom);
      io_oe[N_OUT-1:0]  = N_OUT'($urandom);
      if ($urandom_range(0, 40) == 0) filt_len = FILT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 60) == 0) filt_en = N_IO'({$urandom, $urandom});
      cfg_valid = ($urandom_range(0, 7) == 0);
      if (cfg_valid) rand_cfg();
      rst_n = ($urandom_range(0, 399) != 0);
    end

    // Mid-run reset: everything clears on the next edge, straps re-latch.
    rst_n     = 1'b1;
    cfg_valid = 1'b0;
    filt_en   = '0;
    tb_val[STM]  = 1'b1;
    tb_val[BOOT] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (straps_valid) break;
    end
    check("operational_before_reset", 64'(straps_valid), 64'(1));
    rst_n = 1'b0;
    tick();
    check("mid_rst_io_in",  64'(io_in), 64'(0));
    check("mid_rst_edges",  64'(io_rise | io_fall), 64'(0));
    check("mid_rst_valid",  64'(straps_valid), 64'(0));
    check("mid_rst_ready",  64'(cfg_ready), 64'(0));
    check("mid_rst_straps", 64'({stm, bootsel}), 64'(0));
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (straps_valid) begin
        lat = k;
        break;
      end
    end
    check("relatch_latency", 64'(lat), 64'(SD + 1));
    check("relatch_values",  64'({stm, bootsel}), 64'(2'b10));

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
